// File: rtl/aes_round_ctrl.sv
// Round sequencer for the iterative AES-128 encryption datapath: one key-whitening
// load, ten round/key commits with their round constants, then a one-cycle done.
module aes_round_ctrl #(
  parameter int ROUND_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stall,
  output logic       ld_state,
  output logic       rnd_en,
  output logic       key_en,
  output logic       last_round,
  output logic [7:0] rcon,
  output logic [3:0] round,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] LAST_CYC   = 4'(ROUND_CYCLES - 1);
  localparam logic [3:0] FINAL_RND  = 4'd10;

  state_t     state_q, state_d;
  logic [3:0] round_q, round_d;
  logic [3:0] cyc_q,   cyc_d;
  logic [7:0] rcon_q,  rcon_d;
  logic       commit;

  function automatic logic [7:0] xtime(input logic [7:0] r);
    return r[7] ? ({r[6:0], 1'b0} ^ 8'h1B) : {r[6:0], 1'b0};
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      round_q <= 4'd0;
      cyc_q   <= 4'd0;
      rcon_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      cyc_q   <= cyc_d;
      rcon_q  <= rcon_d;
    end
  end

  // The commit waits out any stall; round, cyc and rcon simply hold meanwhile.
  assign commit = (state_q == ROUND) && (cyc_q == LAST_CYC) && !stall;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    round_d = round_q;
    cyc_d   = cyc_q;
    rcon_d  = rcon_q;

    unique case (state_q)
      IDLE: if (start) state_d = LOAD;
      LOAD: begin
        state_d = ROUND;
        round_d = 4'd1;
        cyc_d   = 4'd0;
        rcon_d  = 8'h01;
      end
      ROUND: begin
        if (commit) begin
          cyc_d = 4'd0;
          if (round_q == FINAL_RND) begin
            state_d = DONE;
            round_d = 4'd0;
            rcon_d  = 8'h00;
          end else begin
            round_d = round_q + 4'd1;
            rcon_d  = xtime(rcon_q);
          end
        end else if (!stall) begin
          cyc_d = cyc_q + 4'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // round and rcon registers are held at zero outside ROUND, so they drive directly.
  always_comb begin
    ld_state   = (state_q == LOAD);
    rnd_en     = commit;
    key_en     = commit;
    last_round = (state_q == ROUND) && (round_q == FINAL_RND);
    rcon       = rcon_q;
    round      = round_q;
    busy       = (state_q == LOAD) || (state_q == ROUND);
    done       = (state_q == DONE);
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Drives two controllers (1- and 4-cycle rounds) with shared directed and random
// stimulus and compares every output each cycle against a run-position model.
module tb_aes_round_ctrl;

  logic clk = 1'b0;
  logic reset, start, stall;
  always #5 clk = ~clk;

  logic       ld1, rnd1, key1, last1, busy1, done1;
  logic [7:0] rcon1;
  logic [3:0] round1;
  logic       ld4, rnd4, key4, last4, busy4, done4;
  logic [7:0] rcon4;
  logic [3:0] round4;

  aes_round_ctrl #(.ROUND_CYCLES(1)) u_rc1 (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .ld_state(ld1), .rnd_en(rnd1), .key_en(key1), .last_round(last1),
    .rcon(rcon1), .round(round1), .busy(busy1), .done(done1)
  );

  aes_round_ctrl #(.ROUND_CYCLES(4)) u_rc4 (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .ld_state(ld4), .rnd_en(rnd4), .key_en(key4), .last_round(last4),
    .rcon(rcon4), .round(round4), .busy(busy4), .done(done4)
  );

  logic [17:0] obs [2];
  assign obs[0] = {ld1, rnd1, key1, last1, rcon1, round1, busy1, done1};
  assign obs[1] = {ld4, rnd4, key4, last4, rcon4, round4, busy4, done4};

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: pos = -1 idle, 0 load, 1..10*RC productive round cycles, 10*RC+1 done.
  int pos       [2];
  int start_cyc [2];
  int stall_cnt [2];
  int rnd_obs   [2];
  int cyc_no;

  function automatic int rc_of(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  function automatic logic [7:0] rcon_of(input int r);
    logic [7:0] tbl [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                             8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
    return tbl[r - 1];
  endfunction

  function automatic logic [17:0] expect_outs(input int p, input int rc, input logic stl);
    logic       e_ld, e_rnd, e_last, e_busy, e_done;
    logic [7:0] e_rcon;
    logic [3:0] e_round;
    int k, r, c;
    e_ld = 0; e_rnd = 0; e_last = 0; e_busy = 0; e_done = 0;
    e_rcon = 8'h00; e_round = 4'd0;
    if (p == 0) begin
      e_ld = 1; e_busy = 1;
    end else if (p >= 1 && p <= 10 * rc) begin
      k = p - 1;
      r = k / rc + 1;
      c = k % rc;
      e_busy  = 1;
      e_rnd   = (c == rc - 1) && !stl;
      e_last  = (r == 10);
      e_rcon  = rcon_of(r);
      e_round = 4'(r);
    end else if (p == 10 * rc + 1) begin
      e_done = 1;
    end
    return {e_ld, e_rnd, e_rnd, e_last, e_rcon, e_round, e_busy, e_done};
  endfunction

  // One clock cycle: apply inputs, compare mid-cycle, then advance the model at the edge.
  task automatic step(input logic rst, input logic st, input logic stl);
    int rc;
    reset = rst; start = st; stall = stl;
    #3;
    for (int i = 0; i < 2; i++) begin
      rc = rc_of(i);
      check($sformatf("outs_rc%0d_cyc%0d", rc, cyc_no), 32'(obs[i]),
            32'(expect_outs(pos[i], rc, stl)));
      if (obs[i][16]) rnd_obs[i]++;
      if (pos[i] >= 1 && pos[i] <= 10 * rc && stl) stall_cnt[i]++;
      if (obs[i][0] === 1'b1) begin
        check($sformatf("latency_rc%0d_cyc%0d", rc, cyc_no), 32'(cyc_no - start_cyc[i]),
              32'(2 + 10 * rc + stall_cnt[i]));
        check($sformatf("commits_rc%0d_cyc%0d", rc, cyc_no), 32'(rnd_obs[i]), 32'd10);
      end
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      rc = rc_of(i);
      if (rst) pos[i] = -1;
      else if (pos[i] == -1) begin
        if (st) begin
          pos[i] = 0;
          start_cyc[i] = cyc_no;
          stall_cnt[i] = 0;
          rnd_obs[i]   = 0;
        end
      end else if (pos[i] == 10 * rc + 1) pos[i] = -1;
      else if (pos[i] >= 1 && pos[i] <= 10 * rc && stl) pos[i] = pos[i];
      else pos[i] = pos[i] + 1;
    end
    cyc_no++;
    #1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b1; stall = 1'b0;
    cyc_no = 0;
    for (int i = 0; i < 2; i++) begin
      pos[i] = -1; start_cyc[i] = 0; stall_cnt[i] = 0; rnd_obs[i] = 0;
    end
    @(posedge clk);
    #1;

    // Reset held with start high: everything stays zero.
    for (int n = 0; n < 5; n++) step(1'b1, 1'b1, 1'b0);

    // Basic run.
    for (int n = 0; n < 50; n++) step(1'b0, n == 0, 1'b0);

    // Three-cycle stall beginning at the round-5 commit cycle.
    for (int n = 0; n < 60; n++) step(1'b0, n == 0, n >= 6 && n <= 8);

    // Reset during round 6, restart in the first cycle after it.
    for (int n = 0; n < 70; n++) step(n == 7, n == 0 || n == 8, 1'b0);

    // Start held high: back-to-back runs with dropped starts in between.
    for (int n = 0; n < 100; n++) step(1'b0, 1'b1, 1'b0);

    // Randomized traffic.
    for (int n = 0; n < 4000; n++)
      step($urandom_range(149) == 0, $urandom_range(3) == 0, $urandom_range(3) == 0);

    // Drain.
    for (int n = 0; n < 60; n++) step(1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
